// File: rtl/enc_dec_pkg.sv
// Shared register offsets, mode encodings and state types for the
// encoder/decoder APB front end.
package enc_dec_pkg;

    localparam logic [1:0] REG_CTRL     = 2'b00;
    localparam logic [1:0] REG_DATA_IN  = 2'b01;
    localparam logic [1:0] REG_CW_WIDTH = 2'b10;
    localparam logic [1:0] REG_NOISE    = 2'b11;

    localparam logic [1:0] CTRL_ENCODE  = 2'b00;
    localparam logic [1:0] CTRL_DECODE  = 2'b01;
    localparam logic [1:0] CTRL_FULL    = 2'b10;

    localparam logic [1:0] CW_WIDTH_8   = 2'b00;
    localparam logic [1:0] CW_WIDTH_16  = 2'b01;
    localparam logic [1:0] CW_WIDTH_32  = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_t;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_START,
        SEQ_BUSY
    } seq_state_t;

endpackage

// File: rtl/apb_slave_fsm.sv
// APB protocol tracker: classifies each cycle as IDLE, SETUP or ACCESS and
// produces the read/write strobes plus a zero-wait-state PREADY.
module apb_slave_fsm
    import enc_dec_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic psel_i,
    input  logic penable_i,
    input  logic pwrite_i,
    output logic wr_en_o,
    output logic rd_en_o,
    output logic pready_o
);

    apb_state_t state_q;
    apb_state_t state_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // state_d is the phase of the current cycle; ACCESS is only legal straight
    // after SETUP, so an enable without a preceding setup is ignored.
    always_comb begin
        state_d  = IDLE;
        wr_en_o  = 1'b0;
        rd_en_o  = 1'b0;
        pready_o = 1'b0;
        if (rst) begin
            if (psel_i && !penable_i) begin
                state_d = SETUP;
            end else if (psel_i && penable_i && (state_q == SETUP)) begin
                state_d = ACCESS;
            end
        end
        // Reads are captured on the SETUP edge, writes commit on the ACCESS edge.
        rd_en_o  = (state_d == SETUP) && !pwrite_i;
        wr_en_o  = (state_d == ACCESS) && pwrite_i;
        pready_o = (state_d == ACCESS);
    end

endmodule

// File: rtl/enc_dec_apb_regs.sv
// APB register bank and start/busy sequencer in front of the encoder/decoder
// core. Configuration writes are refused while an operation is in flight.
module enc_dec_apb_regs
    import enc_dec_pkg::*;
#(
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    input  logic                       PSEL,
    input  logic                       PENABLE,
    input  logic                       PWRITE,
    input  logic [AMBA_WORD-1:0]       PWDATA,
    output logic [AMBA_WORD-1:0]       PRDATA,
    output logic                       PREADY,
    output logic                       PSLVERR,
    output logic [1:0]                 ctrl,
    output logic [AMBA_WORD-1:0]       data_in,
    output logic [1:0]                 codeword_width,
    output logic [AMBA_WORD-1:0]       noise,
    output logic                       start,
    input  logic                       core_done,
    output logic                       busy
);

    logic                 wr_en;
    logic                 rd_en;
    logic                 wr_accept;
    logic [1:0]           reg_sel;
    logic [AMBA_WORD-1:0] rd_mux;

    logic [AMBA_WORD-1:0] ctrl_q,     ctrl_d;
    logic [AMBA_WORD-1:0] data_in_q,  data_in_d;
    logic [AMBA_WORD-1:0] cw_width_q, cw_width_d;
    logic [AMBA_WORD-1:0] noise_q,    noise_d;
    logic [AMBA_WORD-1:0] prdata_q,   prdata_d;
    seq_state_t           seq_q,      seq_d;

    // Only PADDR[3:2] selects a register; the remaining bits are don't-care.
    logic unused_paddr;
    assign unused_paddr = ^{PADDR[AMBA_ADDR_WIDTH-1:4], PADDR[1:0]};
    assign reg_sel      = PADDR[3:2];

    apb_slave_fsm u_apb_fsm (
        .clk       (clk),
        .rst       (rst),
        .psel_i    (PSEL),
        .penable_i (PENABLE),
        .pwrite_i  (PWRITE),
        .wr_en_o   (wr_en),
        .rd_en_o   (rd_en),
        .pready_o  (PREADY)
    );

    assign busy      = (seq_q != SEQ_IDLE);
    assign start     = (seq_q == SEQ_START);
    assign wr_accept = wr_en && !busy;
    assign PSLVERR   = wr_en && busy;

    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            REG_CTRL:     rd_mux = ctrl_q;
            REG_DATA_IN:  rd_mux = data_in_q;
            REG_CW_WIDTH: rd_mux = cw_width_q;
            REG_NOISE:    rd_mux = noise_q;
            default:      rd_mux = '0;
        endcase
    end

    always_comb begin
        ctrl_d     = ctrl_q;
        data_in_d  = data_in_q;
        cw_width_d = cw_width_q;
        noise_d    = noise_q;
        prdata_d   = prdata_q;
        if (wr_accept) begin
            case (reg_sel)
                REG_CTRL:     ctrl_d     = PWDATA;
                REG_DATA_IN:  data_in_d  = PWDATA;
                REG_CW_WIDTH: cw_width_d = PWDATA;
                REG_NOISE:    noise_d    = PWDATA;
                default:      ctrl_d     = ctrl_q;
            endcase
        end
        if (rd_en) begin
            prdata_d = rd_mux;
        end
    end

    // A CTRL write can only be accepted in SEQ_IDLE, so it alone launches the core.
    always_comb begin
        seq_d = seq_q;
        case (seq_q)
            SEQ_IDLE: begin
                if (wr_accept && (reg_sel == REG_CTRL)) begin
                    seq_d = SEQ_START;
                end
            end
            SEQ_START: seq_d = SEQ_BUSY;
            SEQ_BUSY: begin
                if (core_done) begin
                    seq_d = SEQ_IDLE;
                end
            end
            default: seq_d = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ctrl_q     <= '0;
            data_in_q  <= '0;
            cw_width_q <= '0;
            noise_q    <= '0;
            prdata_q   <= '0;
            seq_q      <= SEQ_IDLE;
        end else begin
            ctrl_q     <= ctrl_d;
            data_in_q  <= data_in_d;
            cw_width_q <= cw_width_d;
            noise_q    <= noise_d;
            prdata_q   <= prdata_d;
            seq_q      <= seq_d;
        end
    end

    assign PRDATA         = prdata_q;
    assign ctrl           = ctrl_q[1:0];
    assign data_in        = data_in_q;
    assign codeword_width = cw_width_q[1:0];
    assign noise          = noise_q;

endmodule

// File: tb/tb_enc_dec_apb_regs.sv
// Bench for enc_dec_apb_regs: APB transfers push expected responses into a
// queue that a negedge monitor drains whenever PREADY is seen.
module tb_enc_dec_apb_regs;
    import enc_dec_pkg::*;

    localparam int AW = 20;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] PADDR;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA;
    logic          PREADY;
    logic          PSLVERR;
    logic [1:0]    ctrl;
    logic [DW-1:0] data_in;
    logic [1:0]    codeword_width;
    logic [DW-1:0] noise;
    logic          start;
    logic          core_done;
    logic          busy;

    typedef struct {
        logic          isWrite;
        logic [DW-1:0] rdata;
        logic          err;
        int            id;
    } expItem_t;

    expItem_t expQueue[$];
    expItem_t monItem;
    int checks     = 0;
    int errors     = 0;
    int startCount = 0;
    int txnId      = 0;
    int startBefore;

    enc_dec_apb_regs #(.AMBA_ADDR_WIDTH(AW), .AMBA_WORD(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .PADDR          (PADDR),
        .PSEL           (PSEL),
        .PENABLE        (PENABLE),
        .PWRITE         (PWRITE),
        .PWDATA         (PWDATA),
        .PRDATA         (PRDATA),
        .PREADY         (PREADY),
        .PSLVERR        (PSLVERR),
        .ctrl           (ctrl),
        .data_in        (data_in),
        .codeword_width (codeword_width),
        .noise          (noise),
        .start          (start),
        .core_done      (core_done),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic busIdle();
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
    endtask

    // One SETUP+ACCESS transfer; returns one tick into the cycle after ACCESS so
    // a following call produces a back-to-back transfer.
    task automatic applyStimulus(input logic write, input logic [3:0] addr,
                                 input logic [DW-1:0] data, input logic [DW-1:0] expRdata,
                                 input logic expErr);
        expItem_t e;
        e.isWrite = write;
        e.rdata   = expRdata;
        e.err     = expErr;
        e.id      = txnId;
        txnId++;
        expQueue.push_back(e);
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = write;
        PADDR   = {16'h5A00, addr};
        PWDATA  = data;
        stepCycle();
        PENABLE = 1'b1;
        stepCycle();
    endtask

    always @(negedge clk) begin
        if (start === 1'b1) begin
            startCount++;
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b1 && PREADY === 1'b1) begin
            if (expQueue.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected PREADY: got 1, expected no transfer");
            end else begin
                monItem = expQueue.pop_front();
                checkBit($sformatf("txn%0d pslverr", monItem.id), PSLVERR, monItem.err);
                if (!monItem.isWrite) begin
                    checkOutput($sformatf("txn%0d prdata", monItem.id), PRDATA, monItem.rdata);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b0;
        core_done = 1'b0;
        PADDR     = '0;
        PWDATA    = '0;
        busIdle();
        stepCycle();
        stepCycle();
        checkBit("reset start", start, 1'b0);
        checkBit("reset busy", busy, 1'b0);
        checkBit("reset pready", PREADY, 1'b0);
        checkBit("reset pslverr", PSLVERR, 1'b0);
        checkOutput("reset prdata", PRDATA, 32'h0);
        checkOutput("reset data_in", data_in, 32'h0);
        checkOutput("reset noise", noise, 32'h0);
        checkOutput("reset ctrl", {30'b0, ctrl}, 32'h0);
        checkOutput("reset cw", {30'b0, codeword_width}, 32'h0);
        rst = 1'b1;
        stepCycle();

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 4'(i * 4), 32'h0, 32'h0, 1'b0);
        end
        busIdle();
        stepCycle();

        // Enable without setup must be ignored.
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        PWRITE  = 1'b1;
        PADDR   = 20'h00004;
        PWDATA  = 32'hFFFF_FFFF;
        #1;
        checkBit("no-setup pready", PREADY, 1'b0);
        stepCycle();
        busIdle();
        checkOutput("no-setup data_in", data_in, 32'h0);

        applyStimulus(1'b1, 4'h4, 32'hDEAD_BEEF, 32'h0, 1'b0);
        applyStimulus(1'b1, 4'h8, 32'h0000_0001, 32'h0, 1'b0);
        applyStimulus(1'b1, 4'hC, 32'h0000_0081, 32'h0, 1'b0);
        busIdle();
        checkOutput("data_in after write", data_in, 32'hDEAD_BEEF);
        checkOutput("cw after write", {30'b0, codeword_width}, {30'b0, CW_WIDTH_16});
        checkOutput("noise after write", noise, 32'h0000_0081);
        checkBit("no start from data writes", start, 1'b0);
        applyStimulus(1'b0, 4'h4, 32'h0, 32'hDEAD_BEEF, 1'b0);
        applyStimulus(1'b0, 4'h8, 32'h0, 32'h0000_0001, 1'b0);
        applyStimulus(1'b0, 4'hC, 32'h0, 32'h0000_0081, 1'b0);
        busIdle();
        stepCycle();

        applyStimulus(1'b1, 4'h0, {30'b0, CTRL_FULL}, 32'h0, 1'b0);
        busIdle();
        checkBit("start after ctrl write", start, 1'b1);
        checkBit("busy with start", busy, 1'b1);
        checkOutput("ctrl full", {30'b0, ctrl}, {30'b0, CTRL_FULL});
        stepCycle();
        checkBit("start one cycle", start, 1'b0);
        checkBit("busy held", busy, 1'b1);

        applyStimulus(1'b1, 4'h4, 32'h1234_5678, 32'h0, 1'b1);
        applyStimulus(1'b0, 4'h4, 32'h0, 32'hDEAD_BEEF, 1'b0);
        busIdle();
        checkOutput("data_in locked", data_in, 32'hDEAD_BEEF);
        checkBit("busy after locked write", busy, 1'b1);

        core_done = 1'b1;
        #1;
        checkBit("busy while done sampled", busy, 1'b1);
        stepCycle();
        core_done = 1'b0;
        checkBit("busy drops after done", busy, 1'b0);

        core_done = 1'b1;
        stepCycle();
        core_done = 1'b0;
        stepCycle();
        checkBit("stray done busy", busy, 1'b0);
        checkBit("stray done start", start, 1'b0);

        startBefore = startCount;
        applyStimulus(1'b1, 4'h4, 32'hCAFE_F00D, 32'h0, 1'b0);
        applyStimulus(1'b1, 4'h0, {30'b0, CTRL_DECODE}, 32'h0, 1'b0);
        busIdle();
        checkBit("b2b start", start, 1'b1);
        checkOutput("b2b data_in ready", data_in, 32'hCAFE_F00D);
        checkOutput("b2b ctrl", {30'b0, ctrl}, {30'b0, CTRL_DECODE});
        stepCycle();
        stepCycle();
        checkOutput("b2b start pulses", 32'(startCount - startBefore), 32'd1);
        checkBit("b2b busy", busy, 1'b1);

        rst = 1'b0;
        stepCycle();
        checkBit("mid reset busy", busy, 1'b0);
        checkBit("mid reset start", start, 1'b0);
        checkOutput("mid reset data_in", data_in, 32'h0);
        rst = 1'b1;
        startBefore = startCount;
        stepCycle();
        stepCycle();
        stepCycle();
        checkOutput("no start after reset", 32'(startCount - startBefore), 32'd0);

        applyStimulus(1'b1, 4'h0, {30'b0, CTRL_ENCODE}, 32'h0, 1'b0);
        busIdle();
        checkBit("fresh start", start, 1'b1);
        checkBit("fresh busy", busy, 1'b1);
        stepCycle();
        core_done = 1'b1;
        stepCycle();
        core_done = 1'b0;
        checkBit("fresh op done", busy, 1'b0);
        applyStimulus(1'b0, 4'h0, 32'h0, {30'b0, CTRL_ENCODE}, 1'b0);
        busIdle();
        stepCycle();
        stepCycle();

        checkOutput("scoreboard drained", 32'(expQueue.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
